// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - stall/flush/forwarding control with dmem timeout FSM and perf counters
module hazard_ctrl #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [4:0]       rs1_d_i,
    input  logic [4:0]       rs2_d_i,
    input  logic [4:0]       rs1_e_i,
    input  logic [4:0]       rs2_e_i,
    input  logic [4:0]       rd_e_i,
    input  logic [4:0]       rd_m_i,
    input  logic [4:0]       rd_w_i,
    input  logic             load_e_i,
    input  logic             reg_write_m_i,
    input  logic             reg_write_w_i,
    input  logic             pc_src_e_i,
    input  logic             dmem_req_m_i,
    input  logic             dmem_ready_i,
    output logic [1:0]       forward_a_e_o,
    output logic [1:0]       forward_b_e_o,
    output logic             stall_f_o,
    output logic             stall_d_o,
    output logic             flush_d_o,
    output logic             flush_e_o,
    output logic             stall_em_o,
    output logic             mem_err_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);

    localparam int WC_W = $clog2(MEM_TIMEOUT) + 1;

    typedef enum logic [1:0] {
        S_RUN,
        S_WAIT,
        S_ERR
    } state_t;

    state_t            state_q, state_d;
    logic [WC_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic              lw_stall;
    logic              mem_stall;
    logic              dmem_busy;

    // M result is younger than W, so it takes priority
    always_comb begin
        forward_a_e_o = 2'b00;
        if (reg_write_m_i && rd_m_i != 5'd0 && rd_m_i == rs1_e_i)
            forward_a_e_o = 2'b10;
        else if (reg_write_w_i && rd_w_i != 5'd0 && rd_w_i == rs1_e_i)
            forward_a_e_o = 2'b01;
    end

    always_comb begin
        forward_b_e_o = 2'b00;
        if (reg_write_m_i && rd_m_i != 5'd0 && rd_m_i == rs2_e_i)
            forward_b_e_o = 2'b10;
        else if (reg_write_w_i && rd_w_i != 5'd0 && rd_w_i == rs2_e_i)
            forward_b_e_o = 2'b01;
    end

    assign dmem_busy = dmem_req_m_i & ~dmem_ready_i;
    assign lw_stall  = load_e_i & (rd_e_i != 5'd0) & ((rd_e_i == rs1_d_i) | (rd_e_i == rs2_d_i));
    assign mem_stall = dmem_busy | (state_q == S_ERR);

    // Flushes are suppressed while E is frozen; a pending branch re-presents after release
    assign stall_em_o = mem_stall;
    assign stall_f_o  = lw_stall | mem_stall;
    assign stall_d_o  = lw_stall | mem_stall;
    assign flush_d_o  = pc_src_e_i & ~mem_stall;
    assign flush_e_o  = (lw_stall | pc_src_e_i) & ~mem_stall;
    assign mem_err_o  = (state_q == S_ERR);

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        case (state_q)
            S_RUN: begin
                if (dmem_busy) begin
                    state_d    = S_WAIT;
                    wait_cnt_d = WC_W'(1);
                end
            end
            S_WAIT: begin
                if (dmem_ready_i) begin
                    state_d    = S_RUN;
                    wait_cnt_d = '0;
                end else if (wait_cnt_q == WC_W'(MEM_TIMEOUT - 1)) begin
                    state_d = S_ERR;
                end else begin
                    wait_cnt_d = wait_cnt_q + WC_W'(1);
                end
            end
            S_ERR:   state_d = S_ERR;
            default: state_d = S_RUN;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= S_RUN;
            wait_cnt_q  <= '0;
            stall_cnt_o <= '0;
            flush_cnt_o <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            if (stall_d_o && stall_cnt_o != '1)
                stall_cnt_o <= stall_cnt_o + 1'b1;
            if (flush_d_o && flush_cnt_o != '1)
                flush_cnt_o <= flush_cnt_o + 1'b1;
        end
    end

endmodule
